// File: rtl/kernel_pr_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pr_fifo_pkg
// Description : Shared definitions for the kernel_pr start/token FIFO.
//               - Output-stage state encoding (OUT_EMPTY / OUT_VALID).
//               - clog2_depth: address width needed to index DEPTH entries
//                 (never less than 1).
//               - DEFAULT_DEPTH: default FIFO capacity.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_pr_fifo_pkg;

   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [0:0] {
      OUT_EMPTY = 1'b0,
      OUT_VALID = 1'b1
   } out_state_t;

   // Bits needed to address entries 0..depth-1, minimum one bit.
   function automatic int clog2_depth(input int depth);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((longint'(1) << i) < longint'(depth)) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage : kernel_pr_fifo_pkg
`default_nettype wire

// File: rtl/kernel_pr_start_fifo_v2_srl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pr_start_fifo_v2_srl
// Description : DEPTH x DATA_WIDTH shift register with clock enable and a
//               combinational read tap. On ce, entry 0 takes din and every
//               entry i+1 takes entry i. The newest word sits at index 0,
//               the oldest at index (words held - 1).
// Ports       : clk  - clock
//               ce   - shift enable
//               din  - word shifted into entry 0
//               addr - read tap index
//               dout - entry at addr (0 when addr is out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_pr_start_fifo_v2_srl #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
)(
   input  logic                  clk,
   input  logic                  ce,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] dout
);

   // Storage is intentionally not reset so it maps onto SRL primitives.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (ce) begin
         r_mem[0] <= din;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (ce) begin
               r_mem[gi] <= r_mem[gi-1];
            end
         end
      end
   endgenerate

   // DEPTH need not be a power of two, so guard the unused upper addresses.
   always_comb begin
      dout = '0;
      if (int'(addr) < DEPTH) begin
         dout = r_mem[addr];
      end
   end

endmodule : kernel_pr_start_fifo_v2_srl
`default_nettype wire

// File: rtl/kernel_pr_start_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pr_start_fifo_v2
// Description : First-word fall-through token/data FIFO built on a shift
//               register, with occupancy count, programmable almost-full /
//               almost-empty flags and an optional registered output stage.
//               Any DEPTH >= 2 is supported.
// Optional    : `define KERNEL_PR_FIFO_ERR_CHECK_EN adds sticky if_overflow /
//               if_underflow outputs and count-range assertions.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               if_write_ce/if_write/if_din - write side
//               if_full_n           - 1 = space available
//               if_read_ce/if_read  - read side
//               if_dout/if_empty_n  - head word / head valid
//               if_count            - words held, 0..DEPTH
//               if_almost_full      - count >= AF_LEVEL
//               if_almost_empty     - count <= AE_LEVEL
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_pr_start_fifo_v2
   import kernel_pr_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   parameter int OUT_REG    = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [CNT_WIDTH-1:0]  if_count,
   output logic                  if_almost_full,
   output logic                  if_almost_empty
`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
   ,
   output logic                  if_overflow,
   output logic                  if_underflow
`endif
);

   localparam int ADDR_WIDTH = clog2_depth(DEPTH);
   // With the output register holding the head, the SRL head is one deeper.
   localparam int HEAD_OFFSET = (OUT_REG != 0) ? 1 : 0;

   logic [CNT_WIDTH-1:0]  r_count;
   logic [CNT_WIDTH-1:0]  w_count_nxt;
   logic                  r_full_n;
   logic                  r_empty_n;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_srl_ce;
   logic [ADDR_WIDTH-1:0] w_tap_addr;
   logic [DATA_WIDTH-1:0] w_tap;

   // Qualified handshakes; full/empty gating makes illegal requests no-ops.
   assign w_wr = if_write & if_write_ce & r_full_n;
   assign w_rd = if_read  & if_read_ce  & r_empty_n;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + CNT_WIDTH'(1);
         2'b01:   w_count_nxt = r_count - CNT_WIDTH'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Flags are registered from the next count so they are glitch-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count        <= '0;
         r_empty_n      <= 1'b0;
         r_full_n       <= 1'b1;
         r_almost_full  <= (AF_LEVEL <= 0);
         r_almost_empty <= (AE_LEVEL >= 0);
      end else begin
         r_count        <= w_count_nxt;
         r_empty_n      <= (w_count_nxt != '0);
         r_full_n       <= (w_count_nxt != CNT_WIDTH'(DEPTH));
         r_almost_full  <= (int'(w_count_nxt) >= AF_LEVEL);
         r_almost_empty <= (int'(w_count_nxt) <= AE_LEVEL);
      end
   end

   assign if_count        = r_count;
   assign if_full_n       = r_full_n;
   assign if_empty_n      = r_empty_n;
   assign if_almost_full  = r_almost_full;
   assign if_almost_empty = r_almost_empty;

   // Head of the SRL is the oldest word; address 0 when the SRL is empty.
   always_comb begin
      w_tap_addr = '0;
      if (r_count > CNT_WIDTH'(HEAD_OFFSET)) begin
         w_tap_addr = ADDR_WIDTH'(r_count - CNT_WIDTH'(HEAD_OFFSET + 1));
      end
   end

   kernel_pr_start_fifo_v2_srl #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_srl (
      .clk  (clk),
      .ce   (w_srl_ce),
      .din  (if_din),
      .addr (w_tap_addr),
      .dout (w_tap)
   );

   generate
      if (OUT_REG != 0) begin : g_out_reg
         out_state_t            r_state;
         out_state_t            w_state_nxt;
         logic                  w_srl_has;
         logic                  w_load_din;
         logic                  w_load_srl;
         logic                  w_shift;
         logic [DATA_WIDTH-1:0] r_dout;

         // In OUT_VALID the output register holds one word, the SRL the rest.
         assign w_srl_has = (r_count >= CNT_WIDTH'(2));

         always_ff @(posedge clk) begin
            if (reset) begin
               r_state <= OUT_EMPTY;
            end else begin
               r_state <= w_state_nxt;
            end
         end

         always_comb begin
            w_state_nxt = r_state;
            case (r_state)
               OUT_EMPTY: begin
                  if (w_wr) begin
                     w_state_nxt = OUT_VALID;
                  end
               end
               OUT_VALID: begin
                  if (w_rd && !w_srl_has && !w_wr) begin
                     w_state_nxt = OUT_EMPTY;
                  end
               end
               default: w_state_nxt = OUT_EMPTY;
            endcase
         end

         // A read with a non-empty SRL takes the pre-shift head even when a
         // write shifts the SRL in the same cycle.
         always_comb begin
            w_load_din = 1'b0;
            w_load_srl = 1'b0;
            w_shift    = 1'b0;
            case (r_state)
               OUT_EMPTY: begin
                  w_load_din = w_wr;
               end
               OUT_VALID: begin
                  if (w_rd) begin
                     if (w_srl_has) begin
                        w_load_srl = 1'b1;
                        w_shift    = w_wr;
                     end else begin
                        w_load_din = w_wr;
                     end
                  end else begin
                     w_shift = w_wr;
                  end
               end
               default: begin
                  w_load_din = 1'b0;
               end
            endcase
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               r_dout <= '0;
            end else if (w_load_din) begin
               r_dout <= if_din;
            end else if (w_load_srl) begin
               r_dout <= w_tap;
            end
         end

         assign w_srl_ce = w_shift;
         assign if_dout  = r_dout;
      end else begin : g_out_comb
         assign w_srl_ce = w_wr;
         assign if_dout  = w_tap;
      end
   endgenerate

`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags use the raw requests, before full/empty gating.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (if_write && if_write_ce && !r_full_n) begin
            r_overflow <= 1'b1;
         end
         if (if_read && if_read_ce && !r_empty_n) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign if_overflow  = r_overflow;
   assign if_underflow = r_underflow;

   a_count_range: assert property (@(posedge clk) disable iff (reset)
      (int'(r_count) <= DEPTH));
   a_empty_flag: assert property (@(posedge clk) disable iff (reset)
      (r_empty_n == (r_count != '0)));
`endif

endmodule : kernel_pr_start_fifo_v2
`default_nettype wire

// File: tb/tb_kernel_pr_start_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_pr_start_fifo_v2
// Description : Self-checking bench. Two FIFO instances (combinational and
//               registered output, different almost levels) share one
//               stimulus stream and are checked every cycle against a
//               queue-based reference model, plus hand-computed pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_pr_start_fifo_v2;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int AF0   = DEPTH - 1;
   localparam int AE0   = 1;
   localparam int AF1   = 3;
   localparam int AE1   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          wr, wr_ce, rd, rd_ce;
   logic [DW-1:0] din;

   logic          full_n0, empty_n0, af0, ae0;
   logic [DW-1:0] dout0;
   logic [CW-1:0] count0;
   logic          full_n1, empty_n1, af1, ae1;
   logic [DW-1:0] dout1;
   logic [CW-1:0] count1;
`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
   logic          ovf0, unf0, ovf1, unf1;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: plain queue, oldest word at index 0.
   logic [DW-1:0] q[$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;
   bit            check_en = 1'b0;

   kernel_pr_start_fifo_v2 #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .OUT_REG    (0)
   ) u_dut0 (
      .clk             (clk),
      .reset           (reset),
      .if_write_ce     (wr_ce),
      .if_write        (wr),
      .if_din          (din),
      .if_full_n       (full_n0),
      .if_read_ce      (rd_ce),
      .if_read         (rd),
      .if_dout         (dout0),
      .if_empty_n      (empty_n0),
      .if_count        (count0),
      .if_almost_full  (af0),
      .if_almost_empty (ae0)
`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
      ,
      .if_overflow     (ovf0),
      .if_underflow    (unf0)
`endif
   );

   kernel_pr_start_fifo_v2 #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF1),
      .AE_LEVEL   (AE1),
      .OUT_REG    (1)
   ) u_dut1 (
      .clk             (clk),
      .reset           (reset),
      .if_write_ce     (wr_ce),
      .if_write        (wr),
      .if_din          (din),
      .if_full_n       (full_n1),
      .if_read_ce      (rd_ce),
      .if_read         (rd),
      .if_dout         (dout1),
      .if_empty_n      (empty_n1),
      .if_count        (count1),
      .if_almost_full  (af1),
      .if_almost_empty (ae1)
`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
      ,
      .if_overflow     (ovf1),
      .if_underflow    (unf1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies the FIFO rules to the inputs the DUTs saw at this edge.
   task automatic model_update();
      bit mw;
      bit mr;
      if (reset) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         mw = wr && wr_ce && (q.size() < DEPTH);
         mr = rd && rd_ce && (q.size() > 0);
         if (wr && wr_ce && q.size() == DEPTH) m_ovf = 1'b1;
         if (rd && rd_ce && q.size() == 0)     m_unf = 1'b1;
         if (mr) void'(q.pop_front());
         if (mw) q.push_back(din);
      end
   endtask

   task automatic drive(input bit w, input bit wce, input bit r, input bit rce,
                        input logic [DW-1:0] d, input bit rst);
      reset = rst;
      wr    = w;
      wr_ce = wce;
      rd    = r;
      rd_ce = rce;
      din   = d;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
      drive(w, 1'b1, r, 1'b1, d, 1'b0);
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin : p_compare
      int n;
      if (check_en) begin
         n = q.size();
         check("count0",   count0,   n);
         check("empty_n0", empty_n0, n != 0);
         check("full_n0",  full_n0,  n != DEPTH);
         check("af0",      af0,      n >= AF0);
         check("ae0",      ae0,      n <= AE0);
         check("count1",   count1,   n);
         check("empty_n1", empty_n1, n != 0);
         check("full_n1",  full_n1,  n != DEPTH);
         check("af1",      af1,      n >= AF1);
         check("ae1",      ae1,      n <= AE1);
         if (n > 0) begin
            check("dout0", dout0, q[0]);
            check("dout1", dout1, q[0]);
         end
`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
         check("ovf0", ovf0, m_ovf);
         check("unf0", unf0, m_unf);
         check("ovf1", ovf1, m_ovf);
         check("unf1", unf1, m_unf);
`endif
      end
   end

   initial begin
      int bias;
      bit w, r;
      reset = 1'b1; wr = 1'b0; wr_ce = 1'b0; rd = 1'b0; rd_ce = 1'b0; din = '0;
      drive(0, 0, 0, 0, 8'h00, 1);
      drive(0, 0, 0, 0, 8'h00, 1);
      check_en = 1'b1;

      // Reset state
      check("rst_count",   count0,   0);
      check("rst_empty_n", empty_n0, 0);
      check("rst_full_n",  full_n0,  1);
      check("rst_ae",      ae0,      1);
      check("rst_af",      af0,      0);
      check("rst_dout1",   dout1,    0);

      // Scenario 1: single word, next-cycle visibility
      cyc(1, 0, 8'h01);
      check("s1_empty_n", empty_n0, 1);
      check("s1_dout0",   dout0,    8'h01);
      check("s1_dout1",   dout1,    8'h01);
      check("s1_count",   count0,   1);
      cyc(0, 1, 8'h00);
      check("s1_rd_empty_n", empty_n0, 0);
      check("s1_rd_count",   count1,   0);

      // Scenario 2: fill to DEPTH, reject extra write, drain in order
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 0, DW'(8'h10 + i));
         if (i == 3) check("s2_af_at4", af0, 1);
         if (i == 2) check("s2_af1_at3", af1, 1);
      end
      check("s2_full_n", full_n0, 0);
      check("s2_count",  count0,  5);
      cyc(1, 0, 8'h99);
      check("s2_ovr_count", count0, 5);
      for (int i = 0; i < DEPTH; i++) begin
         check("s2_order0", dout0, 8'h10 + i);
         check("s2_order1", dout1, 8'h10 + i);
         cyc(0, 1, 8'h00);
      end
      check("s2_drained", empty_n1, 0);

      // Scenario 3: simultaneous read/write at count 3
      for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'h20 + i));
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, DW'(8'h23 + i));
         check("s3_count", count0, 3);
      end
      for (int i = 0; i < 3; i++) begin
         check("s3_order1", dout1, 8'h24 + i);
         cyc(0, 1, 8'h00);
      end

      // Scenario 4: registered output, read+write with empty SRL
      cyc(1, 0, 8'hA5);
      check("s4_dout1", dout1, 8'hA5);
      cyc(1, 1, 8'h5A);
      check("s4_dout1_rw",  dout1,    8'h5A);
      check("s4_empty_n1",  empty_n1, 1);
      check("s4_count1",    count1,   1);

      // Scenario 5: reset mid-operation
      cyc(1, 0, 8'h33);
      cyc(1, 0, 8'h44);
      check("s5_pre_count", count0, 3);
      drive(0, 0, 0, 0, 8'h00, 1);
      check("s5_count",   count0,   0);
      check("s5_empty_n", empty_n0, 0);
      check("s5_full_n",  full_n1,  1);
      check("s5_ae",      ae0,      1);
      check("s5_dout1",   dout1,    0);
      cyc(1, 0, 8'h01);
      check("s5_dout0", dout0,  8'h01);
      check("s5_cnt",   count1, 1);
      cyc(0, 1, 8'h00);

`ifdef KERNEL_PR_FIFO_ERR_CHECK_EN
      // Scenario 6: sticky error flags
      cyc(0, 1, 8'h00);
      check("s6_unf", unf0, 1);
      cyc(0, 0, 8'h00);
      check("s6_unf_sticky", unf1, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'(i));
      check("s6_ovf_clear", ovf0, 0);
      cyc(1, 0, 8'hEE);
      check("s6_ovf", ovf1, 1);
      drive(0, 0, 0, 0, 8'h00, 1);
      check("s6_rst_ovf", ovf0, 0);
      check("s6_rst_unf", unf1, 0);
`endif

      // Randomized traffic with fill/drain phases and rare resets
      bias = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) bias = int'($urandom_range(0, 2));
         w = ($urandom_range(0, 99) < ((bias == 0) ? 75 : (bias == 1) ? 25 : 50));
         r = ($urandom_range(0, 99) < ((bias == 0) ? 25 : (bias == 1) ? 75 : 50));
         drive(w, $urandom_range(0, 7) != 0, r, $urandom_range(0, 7) != 0,
               DW'($urandom), $urandom_range(0, 199) == 0);
      end

      @(negedge clk);
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_kernel_pr_start_fifo_v2
`default_nettype wire
